// File: rtl/multiplicador_secuencial.sv
// ---------------------------------------------------------------------------
// multiplicador_secuencial
//
// Sequential shift-and-add unsigned multiplier for the calculator datapath.
// It is the companion of the restoring divider and follows the same
// START/DONE handshake. A request is accepted in S_IDLE. The product is
// built one multiplier bit at a time. Completion is flagged by a
// Moore-decoded DONE.
//
// Ports:
//   CLK    clock, all state changes on the rising edge
//   RST    asynchronous, active-high reset
//   START  level request, only looked at while idle
//   A      multiplicand (W bits, unsigned), captured on the load edge
//   B      multiplier   (W bits, unsigned), captured on the load edge
//   PP     2W-bit product / accumulator, stable from DONE until next load
//   DONE   high exactly while in S_END
//   BUSY   high while in S_CHECK, S_ADD or S_SHIFT
// ---------------------------------------------------------------------------
module multiplicador_secuencial #(
   parameter int W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [W-1:0]     A,
   input  logic [W-1:0]     B,
   output logic [2*W-1:0]   PP,
   output logic             DONE,
   output logic             BUSY
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_ADD   = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_END   = 3'd4;

   logic [2:0]     state;
   logic [2*W-1:0] md;
   logic [W-1:0]   mr;

   // Control FSM and datapath registers in one block. The multiplicand is
   // zero-extended to 2W bits so it can be shifted left without losing bits.
   // The multiplier shifts right, so testing mr[0] walks through B from the
   // LSB upward. The loop stops as soon as no set bits remain, which makes
   // the latency depend on the position of B's highest set bit rather than
   // on W. The add cannot overflow because the running sum never exceeds
   // A*B, and A*B fits in 2W bits. S_END waits for START to drop, so a held
   // request cannot start a second multiplication.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= S_IDLE;
         PP    <= '0;
         md    <= '0;
         mr    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (START) begin
                  md    <= {{W{1'b0}}, A};
                  mr    <= B;
                  PP    <= '0;
                  state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (mr == '0)
                  state <= S_END;
               else if (mr[0])
                  state <= S_ADD;
               else
                  state <= S_SHIFT;
            end
            S_ADD: begin
               PP    <= PP + md;
               state <= S_SHIFT;
            end
            S_SHIFT: begin
               md    <= md << 1;
               mr    <= mr >> 1;
               state <= S_CHECK;
            end
            S_END: begin
               if (!START)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Status flags decode from the state register alone. This keeps them
   // glitch-free with respect to the inputs, and it drives both flags low
   // for any unused encoding.
   assign DONE = (state == S_END);
   assign BUSY = (state == S_CHECK) || (state == S_ADD) || (state == S_SHIFT);

endmodule

// File: doc/multiplicador_secuencial.md
# multiplicador_secuencial

Sequential shift-and-add unsigned multiplier for the calculator datapath: the inverse-operation companion to the restoring divider. It takes a START request, computes the 2W-bit product with its own control FSM and datapath, and reports completion with a Moore-decoded DONE. It sits beside the divider under the calculator top level and uses the same START/DONE convention.

## Interface
- W, default 8: operand width in bits. Product width is 2W.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous and active-high.
- START  input  1  level request, sampled only in S_IDLE.
- A  input  W  multiplicand, unsigned, captured on the load edge.
- B  input  W  multiplier, unsigned, captured on the load edge.
- PP  output  2W  product register; stable from DONE until the next load.
- DONE  output  1  high exactly while in S_END.
- BUSY  output  1  high while in S_CHECK, S_ADD or S_SHIFT.

## Operation
- Internal registers:
  - MD (2W): multiplicand, zero-extended.
  - MR (W): multiplier.
  - PP (2W): accumulator, which is also the output.
  - 3-bit state.
- **S_IDLE** (reset state):
  - If START=1: MD←{W'b0,A}, MR←B, PP←0, go to S_CHECK.
  - Otherwise hold. PP keeps its last value.
- **S_CHECK**:
  - MR==0: go to S_END.
  - Else MR[0]=1: go to S_ADD.
  - Else: go to S_SHIFT.
- **S_ADD**: PP←PP+MD, 2W-bit add with no carry-out kept (it cannot overflow). Go to S_SHIFT.
- **S_SHIFT**: MD←MD<<1, MR←MR>>1. Go to S_CHECK.
- **S_END**: DONE=1, PP held.
  - Stay while START=1.
  - Go to S_IDLE when START=0. This prevents a held START from retriggering.
- Unused state encodings go to S_IDLE on the next edge, with outputs 0.
- Outputs DONE and BUSY decode from the state register only. No output depends combinationally on any input.
- While BUSY, changes on START, A and B are ignored.
- Reset, asynchronous at any time including mid-operation: state=S_IDLE, PP=0, MD=0, MR=0, DONE=0, BUSY=0, effective immediately without a clock edge. After RST deasserts, the first rising edge with START=1 performs a load.

## Timing
- Let n = index of the highest set bit of B plus 1 (n=0 for B=0), and p = popcount(B).
- Latency, counted from the edge that samples START in S_IDLE to the edge after which DONE=1: 2n+p+2 edges.
  - Minimum: 2 edges (B=0).
  - Maximum: 3W+2 edges (B=all ones).
- BUSY rises after the load edge and falls on the same edge that raises DONE.
- PP is final and stable on the edge DONE rises. It does not change again until the next load edge.
- DONE falls one edge after START is sampled low in S_END.
- A new request needs START low for at least one edge in S_END before being raised again in S_IDLE.
- Operands are sampled once. Changing A or B after the load edge does not affect the result.

## Test plan
- **Reset values**: assert RST mid-run with no clock edge → PP=0, DONE=0, BUSY=0 immediately. Release RST and hold START=0 for 5 edges → stays idle, all outputs 0.
- **Typical case** (W=8): A=13, B=11, START held high → DONE after exactly 13 edges, PP=143. DONE stays 1 while START=1. Drop START → DONE=0 one edge later, PP still 143.
- **Zero multiplier**: A=255, B=0 → DONE after 2 edges, PP=0, BUSY high for exactly 1 cycle.
- **Worst case**: A=255, B=255 → DONE after 26 edges, PP=65025. BUSY high for 25 cycles.
- **Ignored inputs while busy**: start A=6, B=7, then change to A=200, B=200 and toggle START while BUSY → PP=42, latency 2·3+3+2=11 edges.
- **Reset mid-operation**: assert RST while in S_ADD during A=13, B=11 → immediate idle, PP=0. A following request A=3, B=5 → PP=15 after 2·3+2+2=10 edges.
